// File: rtl/alarm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alarm_pkg
//  Description : Shared definitions for the alarm unit. Holds the FSM state
//                encoding, the BCD digit limits used to validate an alarm
//                load, the default timing parameters, and a helper that
//                decides whether a set of alarm digits forms a legal
//                24-hour time.
//  Revision    : 1.0 - initial release
// ============================================================================
package alarm_pkg;

    // Alarm FSM states
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_RINGING = 2'd2,
        ST_SNOOZE  = 2'd3
    } alarm_state_t;

    // BCD digit limits, sized to the digit fields they are compared against
    localparam logic [3:0] c_UNITS_MAX        = 4'd9;  // any units digit
    localparam logic [2:0] c_MIN_TENS_MAX     = 3'd5;  // minutes tens
    localparam logic [2:0] c_HOUR_TENS_MAX    = 3'd2;  // hours tens
    localparam logic [3:0] c_HOUR_UNITS_AT_20 = 4'd3;  // hours units once tens == 2

    // Default timing parameters
    localparam int unsigned c_RING_SEC_DEFAULT   = 60;
    localparam int unsigned c_SNOOZE_MIN_DEFAULT = 5;
    localparam int unsigned c_MAX_SNOOZE_DEFAULT = 3;

    // True when the four digits describe a legal HH:MM in 24-hour format
    function automatic logic alarm_digits_valid(
        input logic [3:0] md0,
        input logic [2:0] md1,
        input logic [3:0] hd0,
        input logic [2:0] hd1
    );
        logic ok;
        ok = (md0 <= c_UNITS_MAX) && (md1 <= c_MIN_TENS_MAX) &&
             (hd0 <= c_UNITS_MAX) && (hd1 <= c_HOUR_TENS_MAX);
        // 20..23 only: reject 24..29
        if ((hd1 == c_HOUR_TENS_MAX) && (hd0 > c_HOUR_UNITS_AT_20)) begin
            ok = 1'b0;
        end
        return ok;
    endfunction

endpackage : alarm_pkg
`default_nettype wire

// File: rtl/tick_timer.sv
`default_nettype none
// ============================================================================
//  Module      : tick_timer
//  Description : Counts tick strobes up to MAX_COUNT. A synchronous clear
//                holds the count at zero. o_done is a single-cycle flag that
//                is high on the tick that brings the count to MAX_COUNT, so
//                the owner can act on that very tick. The count saturates
//                at MAX_COUNT if the owner does not clear it.
//  Ports       : clk, rst_n  - clock, async active-low reset
//                i_clr       - hold count at zero (wins over i_tick)
//                i_tick      - advance by one
//                o_done      - terminal tick reached this cycle
//  Revision    : 1.0 - initial release
// ============================================================================
module tick_timer #(
    parameter int unsigned MAX_COUNT = 60
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_tick,
    output logic o_done
);

    localparam int unsigned c_W    = (MAX_COUNT < 1) ? 1 : $clog2(MAX_COUNT + 1);
    localparam logic [c_W-1:0] c_MAX  = c_W'(MAX_COUNT);
    localparam logic [c_W-1:0] c_LAST = c_W'(MAX_COUNT - 1);
    localparam logic [c_W-1:0] c_ONE  = c_W'(1);

    logic [c_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_tick && (r_count < c_MAX)) begin
            r_count <= r_count + c_ONE;
        end
    end

    assign o_done = i_tick && !i_clr && (r_count == c_LAST);

endmodule : tick_timer
`default_nettype wire

// File: rtl/alarm_unit.sv
`default_nettype none
// ============================================================================
//  Module      : alarm_unit
//  Description : Alarm clock controller. Stores a validated HH:MM alarm,
//                detects the moment the running time reaches HH:MM:00 and
//                rings for RING_SEC seconds. The user may stop the alarm or
//                snooze it up to MAX_SNOOZE times for SNOOZE_MIN minutes.
//  Ports       : clk, rst_n              - clock, async active-low reset
//                tick_1hz                - 1 Hz strobe, aligned with time update
//                sq0/sq1 mq0/mq1 hq0/hq1 - current time, BCD
//                alarm_on                - alarm enable level
//                set_en, set_md*/set_hd* - alarm load request and digits
//                snooze, stop            - single-cycle user pulses
//                ring, led, snoozing     - registered status outputs
//                set_err                 - pulse in the cycle of a bad load
//                am0/am1/ah0/ah1         - stored alarm digits
//  Revision    : 1.0 - initial release
// ============================================================================
module alarm_unit
    import alarm_pkg::*;
#(
    parameter int unsigned RING_SEC   = c_RING_SEC_DEFAULT,
    parameter int unsigned SNOOZE_MIN = c_SNOOZE_MIN_DEFAULT,
    parameter int unsigned MAX_SNOOZE = c_MAX_SNOOZE_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_1hz,
    input  logic [3:0] sq0,
    input  logic [2:0] sq1,
    input  logic [3:0] mq0,
    input  logic [2:0] mq1,
    input  logic [3:0] hq0,
    input  logic [2:0] hq1,
    input  logic       alarm_on,
    input  logic       set_en,
    input  logic [3:0] set_md0,
    input  logic [2:0] set_md1,
    input  logic [3:0] set_hd0,
    input  logic [2:0] set_hd1,
    input  logic       snooze,
    input  logic       stop,
    output logic       ring,
    output logic       led,
    output logic       snoozing,
    output logic       set_err,
    output logic [3:0] am0,
    output logic [2:0] am1,
    output logic [3:0] ah0,
    output logic [2:0] ah1
);

    localparam int unsigned c_SNOOZE_TICKS = SNOOZE_MIN * 60;
    localparam int unsigned c_SNZ_W        = (MAX_SNOOZE < 1) ? 1 : $clog2(MAX_SNOOZE + 1);
    localparam logic [c_SNZ_W-1:0] c_SNZ_LIMIT = c_SNZ_W'(MAX_SNOOZE);
    localparam logic [c_SNZ_W-1:0] c_SNZ_ONE   = c_SNZ_W'(1);

    alarm_state_t       r_state;
    logic               r_ring;
    logic               r_led;
    logic               r_snoozing;
    logic [c_SNZ_W-1:0] r_snz_cnt;
    logic               r_match;
    logic [3:0]         r_am0;
    logic [2:0]         r_am1;
    logic [3:0]         r_ah0;
    logic [2:0]         r_ah1;

    logic w_load_ok;
    logic w_match;
    logic w_trigger;
    logic w_ring_done;
    logic w_snz_done;
    logic w_ring_clr;
    logic w_snz_clr;

    // ------------------------------------------------------------------
    // Alarm register
    // ------------------------------------------------------------------
    assign w_load_ok = alarm_digits_valid(set_md0, set_md1, set_hd0, set_hd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_am0 <= '0;
            r_am1 <= '0;
            r_ah0 <= '0;
            r_ah1 <= '0;
        end else if (set_en && w_load_ok) begin
            r_am0 <= set_md0;
            r_am1 <= set_md1;
            r_ah0 <= set_hd0;
            r_ah1 <= set_hd1;
        end
    end

    // Flags the rejected load in the same cycle; forced low while in reset.
    assign set_err = rst_n && set_en && !w_load_ok;

    // ------------------------------------------------------------------
    // Match detection: a match lasts the whole HH:MM:00 second, so only
    // its rising edge may start the alarm.
    // ------------------------------------------------------------------
    assign w_match = ({hq1, hq0, mq1, mq0} == {r_ah1, r_ah0, r_am1, r_am0}) &&
                     (sq1 == 3'd0) && (sq0 == 4'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_match <= 1'b0;
        end else begin
            r_match <= w_match;
        end
    end

    assign w_trigger = w_match && !r_match && !set_en;

    // ------------------------------------------------------------------
    // Ring and snooze timers. Each is held clear outside its own state,
    // so a tick in the cycle that enters the state is never counted.
    // ------------------------------------------------------------------
    assign w_ring_clr = (r_state != ST_RINGING);
    assign w_snz_clr  = (r_state != ST_SNOOZE);

    tick_timer #(
        .MAX_COUNT (RING_SEC)
    ) u_ring_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_clr  (w_ring_clr),
        .i_tick (tick_1hz),
        .o_done (w_ring_done)
    );

    tick_timer #(
        .MAX_COUNT (c_SNOOZE_TICKS)
    ) u_snooze_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_clr  (w_snz_clr),
        .i_tick (tick_1hz),
        .o_done (w_snz_done)
    );

    // ------------------------------------------------------------------
    // Alarm FSM with registered status outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_ring     <= 1'b0;
            r_led      <= 1'b0;
            r_snoozing <= 1'b0;
            r_snz_cnt  <= '0;
        end else if (!alarm_on) begin
            // Disabling the alarm abandons any event in progress
            r_state    <= ST_IDLE;
            r_ring     <= 1'b0;
            r_led      <= 1'b0;
            r_snoozing <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_state <= ST_ARMED;
                end
                ST_ARMED: begin
                    if (w_trigger) begin
                        r_state   <= ST_RINGING;
                        r_ring    <= 1'b1;
                        r_led     <= 1'b0;
                        r_snz_cnt <= '0;
                    end
                end
                ST_RINGING: begin
                    // stop outranks snooze; a snooze past the limit is a stop
                    if (stop || w_ring_done ||
                        (snooze && (r_snz_cnt == c_SNZ_LIMIT))) begin
                        r_state <= ST_ARMED;
                        r_ring  <= 1'b0;
                        r_led   <= 1'b0;
                    end else if (snooze) begin
                        r_state    <= ST_SNOOZE;
                        r_ring     <= 1'b0;
                        r_led      <= 1'b0;
                        r_snoozing <= 1'b1;
                        r_snz_cnt  <= r_snz_cnt + c_SNZ_ONE;
                    end else if (tick_1hz) begin
                        r_led <= !r_led;
                    end
                end
                ST_SNOOZE: begin
                    if (stop) begin
                        r_state    <= ST_ARMED;
                        r_snoozing <= 1'b0;
                    end else if (w_snz_done) begin
                        r_state    <= ST_RINGING;
                        r_ring     <= 1'b1;
                        r_led      <= 1'b0;
                        r_snoozing <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign ring     = r_ring;
    assign led      = r_led;
    assign snoozing = r_snoozing;
    assign am0      = r_am0;
    assign am1      = r_am1;
    assign ah0      = r_ah0;
    assign ah1      = r_ah1;

endmodule : alarm_unit
`default_nettype wire

// File: tb/tb_alarm_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alarm_unit
//  Description : Self-checking bench for alarm_unit. A behavioural model
//                tracks the alarm as minutes-of-day and counts elapsed
//                ticks per ringing/snoozing episode; a compare process
//                checks every output against it each cycle, and directed
//                scenarios pin the model with hand-computed values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alarm_unit;

    localparam int c_RING_SEC   = 60;
    localparam int c_SNOOZE_MIN = 5;
    localparam int c_MAX_SNOOZE = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick_1hz = 1'b0;
    logic [3:0] sq0 = '0;
    logic [2:0] sq1 = '0;
    logic [3:0] mq0 = '0;
    logic [2:0] mq1 = '0;
    logic [3:0] hq0 = '0;
    logic [2:0] hq1 = '0;
    logic       alarm_on = 1'b0;
    logic       set_en = 1'b0;
    logic [3:0] set_md0 = '0;
    logic [2:0] set_md1 = '0;
    logic [3:0] set_hd0 = '0;
    logic [2:0] set_hd1 = '0;
    logic       snooze = 1'b0;
    logic       stop = 1'b0;
    logic       ring;
    logic       led;
    logic       snoozing;
    logic       set_err;
    logic [3:0] am0;
    logic [2:0] am1;
    logic [3:0] ah0;
    logic [2:0] ah1;

    int n_checks = 0;
    int n_errors = 0;
    int t_now    = 0;   // bench wall clock, seconds of day

    alarm_unit #(
        .RING_SEC   (c_RING_SEC),
        .SNOOZE_MIN (c_SNOOZE_MIN),
        .MAX_SNOOZE (c_MAX_SNOOZE)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .tick_1hz (tick_1hz),
        .sq0      (sq0),
        .sq1      (sq1),
        .mq0      (mq0),
        .mq1      (mq1),
        .hq0      (hq0),
        .hq1      (hq1),
        .alarm_on (alarm_on),
        .set_en   (set_en),
        .set_md0  (set_md0),
        .set_md1  (set_md1),
        .set_hd0  (set_hd0),
        .set_hd1  (set_hd1),
        .snooze   (snooze),
        .stop     (stop),
        .ring     (ring),
        .led      (led),
        .snoozing (snoozing),
        .set_err  (set_err),
        .am0      (am0),
        .am1      (am1),
        .ah0      (ah0),
        .ah1      (ah1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model
    // ------------------------------------------------------------------
    localparam int M_IDLE = 0, M_ARMED = 1, M_RING = 2, M_SNZ = 3;

    int m_mode       = M_IDLE;
    int m_elapsed    = 0;    // ticks seen in the current ring/snooze episode
    int m_snz_used   = 0;
    int m_alarm_min  = 0;    // alarm as minutes of day
    bit m_prev_match = 1'b0;
    bit m_led        = 1'b0;
    int m_nxt;
    bit m_match;
    bit m_trig;

    function automatic bit load_ok();
        int hh, mm;
        hh = int'(set_hd1) * 10 + int'(set_hd0);
        mm = int'(set_md1) * 10 + int'(set_md0);
        return (int'(set_hd0) <= 9) && (int'(set_md0) <= 9) && (hh < 24) && (mm < 60);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode       = M_IDLE;
            m_elapsed    = 0;
            m_snz_used   = 0;
            m_alarm_min  = 0;
            m_prev_match = 1'b0;
            m_led        = 1'b0;
        end else begin
            m_match = ((int'(hq1) * 10 + int'(hq0)) * 60 + int'(mq1) * 10 + int'(mq0) == m_alarm_min) &&
                      (int'(sq1) * 10 + int'(sq0) == 0);
            m_trig       = m_match && !m_prev_match && !set_en;
            m_prev_match = m_match;
            if (set_en && load_ok())
                m_alarm_min = (int'(set_hd1) * 10 + int'(set_hd0)) * 60 + int'(set_md1) * 10 + int'(set_md0);

            m_nxt = m_mode;
            if (!alarm_on) m_nxt = M_IDLE;
            else if (m_mode == M_IDLE) m_nxt = M_ARMED;
            else if (m_mode == M_ARMED) begin
                if (m_trig) m_nxt = M_RING;
            end else if (m_mode == M_RING) begin
                if (stop || (snooze && m_snz_used >= c_MAX_SNOOZE) ||
                    (tick_1hz && m_elapsed + 1 >= c_RING_SEC)) m_nxt = M_ARMED;
                else if (snooze) m_nxt = M_SNZ;
            end else begin
                if (stop) m_nxt = M_ARMED;
                else if (tick_1hz && m_elapsed + 1 >= c_SNOOZE_MIN * 60) m_nxt = M_RING;
            end

            if (m_mode == M_ARMED && m_nxt == M_RING) m_snz_used = 0;
            if (m_mode == M_RING && m_nxt == M_SNZ) m_snz_used++;
            if (m_nxt == M_RING && m_mode == M_RING) m_led = m_led ^ tick_1hz;
            else m_led = 1'b0;
            if (m_nxt != m_mode) m_elapsed = 0;
            else if (tick_1hz) m_elapsed++;
            m_mode = m_nxt;
        end
    end

    // Compare every cycle, mid-cycle
    always @(negedge clk) begin
        chk("ring", ring, (m_mode == M_RING));
        chk("snoozing", snoozing, (m_mode == M_SNZ));
        chk("led", led, m_led);
        chk("set_err", set_err, rst_n && set_en && !load_ok());
        chk("alarm_hours", int'(ah1) * 10 + int'(ah0), m_alarm_min / 60);
        chk("alarm_minutes", int'(am1) * 10 + int'(am0), m_alarm_min % 60);
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    // One clock cycle of inputs; returns 2 time units after the edge that
    // starts the cycle, so registered outputs reflect the previous cycle.
    task automatic cyc(input bit tk, input bit snz = 1'b0, input bit stp = 1'b0);
        @(posedge clk);
        #1;
        tick_1hz = tk;
        snooze   = snz;
        stop     = stp;
        if (tk) t_now = (t_now + 1) % 86400;
        sq0 = 4'((t_now % 60) % 10);
        sq1 = 3'((t_now % 60) / 10);
        mq0 = 4'(((t_now / 60) % 60) % 10);
        mq1 = 3'(((t_now / 60) % 60) / 10);
        hq0 = 4'((t_now / 3600) % 10);
        hq1 = 3'((t_now / 3600) / 10);
        #1;
    endtask

    task automatic tick_pair();
        cyc(1'b1);
        cyc(1'b0);
    endtask

    task automatic load(input int hd1, input int hd0, input int md1, input int md0, input bit exp_err);
        set_hd1 = 3'(hd1);
        set_hd0 = 4'(hd0);
        set_md1 = 3'(md1);
        set_md0 = 4'(md0);
        set_en  = 1'b1;
        #1;
        chk("set_err_pulse", set_err, exp_err);
        cyc(1'b0);
        set_en = 1'b0;
    endtask

    task automatic ring_at_0730();
        t_now = 7 * 3600 + 29 * 60 + 59;
        cyc(1'b0);
        cyc(1'b1);          // 07:30:00
        cyc(1'b0);
    endtask

    int n;

    initial begin
        // Reset state
        repeat (3) cyc(1'b0);
        chk("reset_outputs", {ring, led, snoozing, set_err}, 4'b0000);
        chk("reset_alarm", {ah1, ah0, am1, am0}, 14'd0);
        rst_n    = 1'b1;
        alarm_on = 1'b1;
        cyc(1'b0);

        // Load 07:30
        load(0, 7, 3, 0, 1'b0);
        chk("alarm_0730", {ah1, ah0, am1, am0}, {3'd0, 4'd7, 3'd3, 4'd0});

        // Approach 07:30:00 and ring
        t_now = 7 * 3600 + 29 * 60 + 50;
        cyc(1'b0);
        repeat (9) tick_pair();
        chk("no_ring_0729_59", ring, 1'b0);
        cyc(1'b1);
        cyc(1'b0);
        chk("ring_starts", ring, 1'b1);
        chk("led_at_entry", led, 1'b0);
        tick_pair();
        chk("led_toggle_1", led, 1'b1);
        tick_pair();
        chk("led_toggle_2", led, 1'b0);

        // Timeout after RING_SEC ticks
        n = 2;
        while (ring && n < 200) begin
            tick_pair();
            n++;
        end
        chk("ring_timeout_ticks", n, 60);
        chk("led_after_timeout", led, 1'b0);
        repeat (5) tick_pair();
        chk("no_retrigger", ring, 1'b0);

        // Three snoozes, then a fourth acting as stop
        ring_at_0730();
        chk("ring_again", ring, 1'b1);
        for (int k = 0; k < 3; k++) begin
            cyc(1'b0, 1'b1);
            cyc(1'b0);
            chk("snooze_entered", {ring, snoozing}, 2'b01);
            n = 0;
            while (!ring && n < 400) begin
                tick_pair();
                n++;
            end
            chk("snooze_ticks", n, 300);
        end
        cyc(1'b0, 1'b1);
        cyc(1'b0);
        chk("fourth_snooze_stops", {ring, snoozing, led}, 3'b000);
        repeat (3) tick_pair();

        // stop and snooze together while ringing
        ring_at_0730();
        chk("ring_for_stop", ring, 1'b1);
        cyc(1'b0, 1'b1, 1'b1);
        cyc(1'b0);
        chk("stop_wins", {ring, snoozing}, 2'b00);
        repeat (3) tick_pair();
        chk("stays_quiet", ring, 1'b0);

        // Invalid and valid loads
        load(2, 4, 0, 0, 1'b1);
        chk("keep_after_2400", {ah1, ah0, am1, am0}, {3'd0, 4'd7, 3'd3, 4'd0});
        load(1, 2, 6, 0, 1'b1);
        chk("keep_after_1260", {ah1, ah0, am1, am0}, {3'd0, 4'd7, 3'd3, 4'd0});
        load(2, 3, 5, 9, 1'b0);
        chk("alarm_2359", {ah1, ah0, am1, am0}, {3'd2, 4'd3, 3'd5, 4'd9});

        // Trigger suppressed while set_en is held
        t_now = 23 * 3600 + 58 * 60 + 59;
        cyc(1'b0);
        set_en = 1'b1;
        cyc(1'b1);          // 23:59:00 with set_en high
        cyc(1'b0);
        chk("suppressed_by_set", ring, 1'b0);
        set_en = 1'b0;
        cyc(1'b0);
        cyc(1'b0);
        chk("no_late_trigger", ring, 1'b0);

        // Reset during snooze
        t_now = 23 * 3600 + 58 * 60 + 59;
        cyc(1'b0);
        cyc(1'b1);
        cyc(1'b0);
        chk("ring_2359", ring, 1'b1);
        cyc(1'b0, 1'b1);
        cyc(1'b0);
        chk("snoozing_2359", snoozing, 1'b1);
        repeat (4) tick_pair();
        rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", {ring, led, snoozing, set_err}, 4'b0000);
        chk("async_reset_alarm", {ah1, ah0, am1, am0}, 14'd0);
        repeat (3) cyc(1'b0);
        rst_n = 1'b1;
        repeat (4) tick_pair();
        chk("quiet_after_reset", {ring, snoozing}, 2'b00);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_alarm_unit
`default_nettype wire

// File: doc/alarm_unit.md
ALARM_UNIT -- requirements
Module: alarm_unit

Interface
REQ-001 Parameter RING_SEC, default 60: ringing timeout in seconds.
REQ-002 Parameter SNOOZE_MIN, default 5: snooze length in minutes.
REQ-003 Parameter MAX_SNOOZE, default 3: maximum snoozes per alarm event.
REQ-004 clk  input  1  single system clock; all state on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 tick_1hz  input  1  one-cycle strobe, once per second, aligned with the time-counter update.
REQ-007 sq0/sq1  input  4/3  current seconds BCD digits (units/tens).
REQ-008 mq0/mq1  input  4/3  current minutes BCD digits.
REQ-009 hq0/hq1  input  4/3  current hours BCD digits (24 h).
REQ-010 alarm_on  input  1  level; alarm enable.
REQ-011 set_en  input  1  level; load alarm time from set_* digits.
REQ-012 set_md0/set_md1/set_hd0/set_hd1  input  4/3/4/3  alarm minute/hour BCD digits.
REQ-013 snooze, stop  input  1 each  one-cycle pulses, pre-debounced and synchronous to clk.
REQ-014 ring  output  1  level; high while state is RINGING.
REQ-015 led  output  1  toggles on each tick_1hz while RINGING; 0 otherwise.
REQ-016 snoozing  output  1  high while state is SNOOZE.
REQ-017 set_err  output  1  one-cycle pulse on a rejected load.
REQ-018 am0/am1/ah0/ah1  output  4/3/4/3  stored alarm digits, for display.

Function
REQ-019 FSM states: IDLE, ARMED, RINGING, SNOOZE.
REQ-020 match = (hq1,hq0,mq1,mq0 equal stored alarm) and sq1==0 and sq0==0; trigger = rising edge of match (match and not match registered), evaluated every clk.
REQ-021 IDLE -> ARMED when alarm_on=1; any state -> IDLE when alarm_on=0 (highest priority).
REQ-022 ARMED -> RINGING on trigger with set_en=0; the ring counter clears and snooze_cnt clears.
REQ-023 RINGING -> ARMED on stop, or when the ring counter reaches RING_SEC ticks.
REQ-024 RINGING -> SNOOZE on snooze when snooze_cnt < MAX_SNOOZE; snooze_cnt increments and the snooze counter clears.
REQ-025 A snooze pulse when snooze_cnt == MAX_SNOOZE acts as stop.
REQ-026 SNOOZE -> RINGING when the snooze counter reaches SNOOZE_MIN*60 ticks; the ring counter clears and snooze_cnt is kept.
REQ-027 SNOOZE -> ARMED on stop.
REQ-028 stop and snooze in the same cycle: stop wins.
REQ-029 Counters advance only on tick_1hz; a tick in the cycle of state entry is not counted.
REQ-030 Counter width: $clog2(max count + 1) bits; no wrap reachable.
REQ-031 State transitions take effect one cycle after the causing input; ring/snoozing/led are registered.
REQ-032 set_en loads the alarm register every cycle it is high, if digits are valid BCD:
- minute tens <= 5, minute units <= 9
- hour tens <= 2, hour units <= 9, with hour units <= 3 when hour tens == 2.
REQ-033 An invalid load leaves the register unchanged and pulses set_err for that cycle.
REQ-034 While set_en=1, trigger is suppressed; a set in RINGING/SNOOZE does not change state.
REQ-035 led resets to 0 on every exit from RINGING.

Reset
REQ-036 rst_n=0 asynchronously forces: state IDLE; ring, led, snoozing, set_err = 0; alarm register 00:00; all counters and match register = 0.
REQ-037 Reset mid-ring or mid-snooze abandons the event; after release, the FSM re-enters ARMED only through REQ-021.

Structure
REQ-038 Shared package alarm_pkg holds:
- FSM state encoding
- BCD limit constants (5, 9, 2, 3)
- default RING_SEC, SNOOZE_MIN, MAX_SNOOZE.
REQ-039 One sub-module, tick_timer: tick-gated counter with clear and terminal-count flag, instanced for the ring and snooze counters.

Verification
REQ-040 Alarm 07:30, alarm_on=1, time steps 07:29:59 -> 07:30:00 → ring=1 one cycle later; led toggles each tick.
REQ-041 Ringing with no input, RING_SEC=60 → ring=0 and state ARMED after 60 ticks; no retrigger during 07:30:00-07:30:59.
REQ-042 snooze three times, SNOOZE_MIN=5 → ring resumes after 300 ticks each time; a fourth snooze gives ring=0 and ARMED.
REQ-043 stop and snooze in the same cycle while ringing → ARMED, snoozing=0.
REQ-044 set 24:00 or 12:60 → set_err pulses and am/ah are unchanged; set 23:59 → stored.
REQ-045 rst_n low during SNOOZE → all outputs 0 immediately, alarm reads 00:00.
